// File: rtl/cordic_sweep_ctrl.sv
// cordic_sweep_ctrl
//   Frequency-sweep scheduler for the 12-bit CORDIC waveform generator.
//   The host loads start/stop/step/dwell through a byte-wide register port.
//   A CTRL write with `go` then walks freq_out from start to stop. Each value
//   is held for dwell+1 cycles. The sweep runs single-shot, repeating, or
//   ping-pong (ping-pong only when SWEEP_PINGPONG_EN is defined).
//
// Ports
//   clk1        in   clock (single domain)
//   reset       in   synchronous active-high reset
//   cfg_we      in   register write strobe
//   cfg_addr    in   register address (0..7)
//   cfg_wdata   in   register write data
//   freq_out    out  registered frequency word to the generator
//   wave_out    out  registered waveform select to the generator
//   busy        out  sweep in progress (DWELL state)
//   step_tick   out  one-cycle pulse when the sweep changes freq_out
//   done        out  one-cycle pulse at the end of a single-shot sweep
//   dbg_state_o out  FSM state: 0 IDLE, 1 LOAD, 2 DWELL, 3 HOLD
//
// Configuration macro: SWEEP_PINGPONG_EN (enables ping-pong mode, CTRL bit5)
//
// Register/CTRL handshake: a write takes effect on the clock edge where
// cfg_we is sampled high. go/abort act only in that cycle. abort beats go.
// go is honoured only from IDLE or HOLD.
module cordic_sweep_ctrl #(
  parameter int FREQ_W  = 13,
  parameter int DWELL_W = 16
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_addr,
  input  logic [7:0]        cfg_wdata,
  output logic [FREQ_W-1:0] freq_out,
  output logic [1:0]        wave_out,
  output logic              busy,
  output logic              step_tick,
  output logic              done,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DWELL = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  // Host register file
  logic [7:0]         start_l_q, stop_l_q, step_q, dwell_l_q;
  logic [FREQ_W-9:0]  start_h_q, stop_h_q;
  logic [DWELL_W-9:0] dwell_h_q;

  always_ff @(posedge clk1) begin
    if (reset) begin
      start_l_q <= '0;
      start_h_q <= '0;
      stop_l_q  <= '0;
      stop_h_q  <= '0;
      step_q    <= '0;
      dwell_l_q <= '0;
      dwell_h_q <= '0;
    end else if (cfg_we) begin
      case (cfg_addr)
        3'd0:    start_l_q <= cfg_wdata;
        3'd1:    start_h_q <= cfg_wdata[FREQ_W-9:0];
        3'd2:    stop_l_q  <= cfg_wdata;
        3'd3:    stop_h_q  <= cfg_wdata[FREQ_W-9:0];
        3'd4:    step_q    <= cfg_wdata;
        3'd5:    dwell_l_q <= cfg_wdata;
        3'd6:    dwell_h_q <= cfg_wdata[DWELL_W-9:0];
        default: ;
      endcase
    end
  end

  logic ctrl_wr, go, abort;
  assign ctrl_wr = cfg_we && (cfg_addr == 3'd7);
  assign abort   = ctrl_wr && cfg_wdata[1];
  assign go      = ctrl_wr && cfg_wdata[0] && !cfg_wdata[1];

  // One step from cur toward tgt. The arithmetic is one bit wider than the
  // word, so the result clamps at tgt and never wraps past 0 or full scale.
  function automatic logic [FREQ_W-1:0] step_toward(
    input logic [FREQ_W-1:0] cur,
    input logic [FREQ_W-1:0] tgt,
    input logic              up,
    input logic [7:0]        stp
  );
    logic [FREQ_W:0] wide;
    logic [FREQ_W:0] stp_w;
    stp_w = {{(FREQ_W-7){1'b0}}, stp};
    if (up) begin
      wide = {1'b0, cur} + stp_w;
      step_toward = (wide >= {1'b0, tgt}) ? tgt : wide[FREQ_W-1:0];
    end else begin
      wide = {1'b0, cur} - stp_w;
      step_toward = (wide[FREQ_W] || (wide[FREQ_W-1:0] <= tgt)) ? tgt : wide[FREQ_W-1:0];
    end
  endfunction

  state_t              state_q, state_d;
  logic [FREQ_W-1:0]   freq_q, freq_d, target_q, target_d;
  logic [FREQ_W-1:0]   lat_start_q, lat_start_d, lat_stop_q, lat_stop_d;
  logic [7:0]          lat_step_q, lat_step_d;
  logic [DWELL_W-1:0]  lat_dwell_q, lat_dwell_d, cnt_q, cnt_d;
  logic [1:0]          wave_q, wave_d, lat_wave_q, lat_wave_d;
  logic                lat_rep_q, lat_rep_d, dir_up_q, dir_up_d;
  logic                busy_q, busy_d, tick_q, tick_d, done_q, done_d;
  logic [FREQ_W-1:0]   nxt;
`ifdef SWEEP_PINGPONG_EN
  logic                lat_pp_q, lat_pp_d;
  logic [FREQ_W-1:0]   swap_target, bounce;
`endif

  always_comb begin
    state_d     = state_q;
    freq_d      = freq_q;
    wave_d      = wave_q;
    target_d    = target_q;
    dir_up_d    = dir_up_q;
    cnt_d       = cnt_q;
    lat_start_d = lat_start_q;
    lat_stop_d  = lat_stop_q;
    lat_step_d  = lat_step_q;
    lat_dwell_d = lat_dwell_q;
    lat_wave_d  = lat_wave_q;
    lat_rep_d   = lat_rep_q;
    tick_d      = 1'b0;
    done_d      = 1'b0;
    nxt         = step_toward(freq_q, target_q, dir_up_q, lat_step_q);
`ifdef SWEEP_PINGPONG_EN
    lat_pp_d    = lat_pp_q;
    // End of a leg: head back toward the other endpoint.
    swap_target = (target_q == lat_stop_q) ? lat_start_q : lat_stop_q;
    bounce      = step_toward(freq_q, swap_target, ~dir_up_q, lat_step_q);
`endif

    case (state_q)
      S_IDLE, S_HOLD: begin
        if (go) begin
          // Mode/wave come from the go write itself; everything else from
          // the register file as it stands now.
          state_d     = S_LOAD;
          lat_start_d = {start_h_q, start_l_q};
          lat_stop_d  = {stop_h_q, stop_l_q};
          lat_step_d  = (step_q == 8'd0) ? 8'd1 : step_q;
          lat_dwell_d = {dwell_h_q, dwell_l_q};
          lat_wave_d  = cfg_wdata[3:2];
          lat_rep_d   = cfg_wdata[4];
`ifdef SWEEP_PINGPONG_EN
          lat_pp_d    = cfg_wdata[5];
`endif
        end
      end
      S_LOAD: begin
        freq_d   = lat_start_q;
        wave_d   = lat_wave_q;
        target_d = lat_stop_q;
        dir_up_d = (lat_stop_q >= lat_start_q);
        cnt_d    = lat_dwell_q;
        state_d  = S_DWELL;
      end
      S_DWELL: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (freq_q != target_q) begin
          freq_d = nxt;
          cnt_d  = lat_dwell_q;
          tick_d = 1'b1;
        end else begin
`ifdef SWEEP_PINGPONG_EN
          if (lat_pp_q) begin
            target_d = swap_target;
            dir_up_d = ~dir_up_q;
            freq_d   = bounce;
            cnt_d    = lat_dwell_q;
            tick_d   = (bounce != freq_q);
          end else
`endif
          if (lat_rep_q) begin
            freq_d = lat_start_q;
            cnt_d  = lat_dwell_q;
            tick_d = 1'b1;
          end else begin
            state_d = S_HOLD;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort freezes the outputs where they are and suppresses any pulse.
    if (abort) begin
      state_d = S_IDLE;
      freq_d  = freq_q;
      wave_d  = wave_q;
      tick_d  = 1'b0;
      done_d  = 1'b0;
    end

    busy_d = (state_d == S_DWELL);
  end

  always_ff @(posedge clk1) begin
    if (reset) begin
      state_q     <= S_IDLE;
      freq_q      <= '0;
      wave_q      <= '0;
      target_q    <= '0;
      dir_up_q    <= 1'b0;
      cnt_q       <= '0;
      lat_start_q <= '0;
      lat_stop_q  <= '0;
      lat_step_q  <= '0;
      lat_dwell_q <= '0;
      lat_wave_q  <= '0;
      lat_rep_q   <= 1'b0;
      busy_q      <= 1'b0;
      tick_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SWEEP_PINGPONG_EN
      lat_pp_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      freq_q      <= freq_d;
      wave_q      <= wave_d;
      target_q    <= target_d;
      dir_up_q    <= dir_up_d;
      cnt_q       <= cnt_d;
      lat_start_q <= lat_start_d;
      lat_stop_q  <= lat_stop_d;
      lat_step_q  <= lat_step_d;
      lat_dwell_q <= lat_dwell_d;
      lat_wave_q  <= lat_wave_d;
      lat_rep_q   <= lat_rep_d;
      busy_q      <= busy_d;
      tick_q      <= tick_d;
      done_q      <= done_d;
`ifdef SWEEP_PINGPONG_EN
      lat_pp_q    <= lat_pp_d;
`endif
    end
  end

  assign freq_out    = freq_q;
  assign wave_out    = wave_q;
  assign busy        = busy_q;
  assign step_tick   = tick_q;
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule
